// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential RV32M divider.
// Op encoding matches funct3[1:0] of the M-extension divide group.
package div_pkg;

    localparam int XLEN        = 32;
    localparam int DIV_LATENCY = 36;
    localparam int DIV_STEPS   = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_A,
        S_ABS_B,
        S_DIV,
        S_NEG_Q,
        S_NEG_R,
        S_DONE
    } div_state_e;

    function automatic logic op_is_quot(input div_op_e op);
        return ~op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/div32_seq_add32.sv
// add32: 32-bit adder with carry-in, carry-out and signed overflow.
// Shared by every divider state for negation and trial subtraction.
module add32
    import div_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            cin_i,
    output logic [XLEN-1:0] sum_o,
    output logic            cout_o,
    output logic            ovf_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{XLEN{1'b0}}, cin_i};
    assign ovf_o = (a_i[XLEN-1] == b_i[XLEN-1]) && (sum_o[XLEN-1] != a_i[XLEN-1]);

endmodule

// File: rtl/div32_seq.sv
// div32_seq: multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU.
// Operands are made positive, divided, then the signs are reapplied.
module div32_seq
    import div_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    div_state_e      state_q, state_d;
    div_op_e         op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] r_q, r_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic            dz_q, dz_d;

    logic [XLEN-1:0] add_a, add_b, add_sum;
    logic            add_cin, add_cout;
    logic            add_ovf_unused;
    logic [XLEN-1:0] r_shift;
    logic            accept;

    add32 u_add (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .ovf_o  (add_ovf_unused)
    );

    assign r_shift = {r_q[XLEN-2:0], a_q[XLEN-1]};
    assign accept  = r_q[XLEN-1] | add_cout;

    // Adder operand select depends only on the current state.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state_q)
            S_ABS_A: begin add_a = ~a_q; add_cin = 1'b1; end
            S_ABS_B: begin add_a = ~b_q; add_cin = 1'b1; end
            S_DIV:   begin add_a = r_shift; add_b = ~b_q; add_cin = 1'b1; end
            S_NEG_Q: begin add_a = ~a_q; add_cin = 1'b1; end
            S_NEG_R: begin add_a = ~r_q; add_cin = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start && !i_flush) begin
                    op_d    = div_op_e'(i_op);
                    a_d     = i_rs1;
                    b_d     = i_rs2;
                    r_d     = '0;
                    cnt_d   = '0;
                    sa_d    = i_rs1[XLEN-1] & op_is_signed(i_op);
                    sb_d    = i_rs2[XLEN-1] & op_is_signed(i_op);
                    dz_d    = (i_rs2 == '0);
                    state_d = S_ABS_A;
                end
            end
            S_ABS_A: begin
                if (sa_q) a_d = add_sum;
                state_d = S_ABS_B;
            end
            S_ABS_B: begin
                if (sb_q) b_d = add_sum;
                state_d = S_DIV;
            end
            S_DIV: begin
                a_d   = {a_q[XLEN-2:0], accept};
                r_d   = accept ? add_sum : r_shift;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_STEPS - 1)) state_d = S_NEG_Q;
            end
            S_NEG_Q: begin
                if ((sa_q ^ sb_q) && !dz_q) a_d = add_sum;
                state_d = S_NEG_R;
            end
            S_NEG_R: begin
                if (sa_q) r_d = add_sum;
                res_d   = op_is_quot(op_q) ? a_q : (sa_q ? add_sum : r_q);
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A kill leaves the previously delivered result visible.
        if (i_flush && state_q != S_IDLE) begin
            state_d = S_IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            op_q    <= DIV;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
        end
    end

    assign o_busy   = (state_q != S_IDLE);
    assign o_valid  = (state_q == S_DONE);
    assign o_result = res_q;

endmodule
